serial_adder_ctrl: RTL and testbench

- Bit-serial adder sequencer that sits around the existing single-bit full adder and drives it.
- Each cycle it feeds one operand bit pair plus the stored carry to the full adder, then captures the returned sum and carry-out.
- It assembles a WIDTH-bit result over WIDTH cycles, trading the area of a ripple-carry adder for latency.
- Used where wide additions are infrequent and gate count matters.

---
 rtl/serial_adder_ctrl.sv | 108 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: drives an external single-bit full adder one bit
// pair per cycle, LSB first, and assembles a WIDTH-bit sum plus final carry.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] areg_q;
  logic [WIDTH-1:0] breg_q;
  logic [WIDTH-1:0] psum_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  // Next partial sum: the returned bit enters at the MSB so the LSB lands at bit 0 last.
  logic [WIDTH-1:0] psum_d;
  assign psum_d = {fa_sum, psum_q[WIDTH-1:1]};

  // Sequencer: one state register, all control outputs registered alongside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      areg_q  <= '0;
      breg_q  <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            areg_q  <= a;
            breg_q  <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          psum_q  <= psum_d;
          areg_q  <= {1'b0, areg_q[WIDTH-1:1]};
          breg_q  <= {1'b0, breg_q[WIDTH-1:1]};
          carry_q <= fa_cout;
          // Result registers change only here, so they never show a partial sum.
          if (cnt_q == LAST_BIT) begin
            sum_q   <= psum_d;
            cout_q  <= fa_cout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign fa_a   = areg_q[0];
  assign fa_b   = breg_q[0];
  assign fa_cin = carry_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign sum    = sum_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomized bench for serial_adder_ctrl with a behavioural full
// adder and an arithmetic reference model.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         fa_a;
  logic         fa_b;
  logic         fa_cin;
  logic         fa_sum;
  logic         fa_cout;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] prev_sum;
  logic         prev_cout;
  logic [W-1:0] exp_sum;
  logic         exp_cout;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .fa_a    (fa_a),
    .fa_b    (fa_b),
    .fa_cin  (fa_cin),
    .fa_sum  (fa_sum),
    .fa_cout (fa_cout),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout)
  );

  // The existing single-bit full adder the sequencer drives.
  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Present an operation; it is accepted on the next edge from IDLE or DONE.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    logic [W:0] r;
    start = 1'b1;
    a     = av;
    b     = bv;
    cin   = cv;
    r = (W+1)'(av) + (W+1)'(bv) + (W+1)'(cv);
    exp_sum  = r[W-1:0];
    exp_cout = r[W];
    @(posedge clk); #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_done", 32'(done), 32'd0);
    chk("accept_hold_sum", 32'(sum), 32'(prev_sum));
  endtask

  // Run the remaining shift edges; optionally fire an ignored start mid-operation.
  task automatic finish_op(input bit inject);
    for (int k = 1; k < int'(W); k++) begin
      @(posedge clk); #1;
      chk("shift_busy", 32'(busy), 32'd1);
      chk("shift_done", 32'(done), 32'd0);
      chk("shift_hold_sum", 32'(sum), 32'(prev_sum));
      chk("shift_hold_cout", 32'(cout), 32'(prev_cout));
      if (inject && k == 3) begin
        start = 1'b1;
        a     = 8'h11;
        b     = 8'h22;
      end else begin
        start = 1'b0;
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("final_busy", 32'(busy), 32'd0);
    chk("final_done", 32'(done), 32'd1);
    chk("final_sum", 32'(sum), 32'(exp_sum));
    chk("final_cout", 32'(cout), 32'(exp_cout));
    prev_sum  = exp_sum;
    prev_cout = exp_cout;
  endtask

  task automatic idle_check();
    @(posedge clk); #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_sum", 32'(sum), 32'(prev_sum));
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    prev_sum  = '0;
    prev_cout = 1'b0;
    exp_sum   = '0;
    exp_cout  = 1'b0;

    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
    #11 rst = 1'b0;
    @(posedge clk); #1;

    launch(8'h00, 8'h00, 1'b0); finish_op(1'b0); idle_check();
    launch(8'hFF, 8'h01, 1'b0); finish_op(1'b0); idle_check();
    launch(8'h7F, 8'h01, 1'b0); finish_op(1'b0); idle_check();
    launch(8'hA5, 8'h5A, 1'b1); finish_op(1'b0); idle_check();
    launch(8'h0F, 8'h01, 1'b0); finish_op(1'b1); idle_check();

    // Back-to-back: start held into DONE starts a new SHIFT with no IDLE cycle.
    launch(8'h10, 8'h20, 1'b0); finish_op(1'b0);
    launch(8'h03, 8'h04, 1'b0); finish_op(1'b0); idle_check();

    // Asynchronous reset between edges, mid-SHIFT.
    launch(8'h5A, 8'h33, 1'b1);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    prev_sum  = '0;
    prev_cout = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_idle_busy", 32'(busy), 32'd0);
    end
    launch(8'h02, 8'h02, 1'b0); finish_op(1'b0); idle_check();

    // Randomized operations with random back-to-back chaining and ignored starts.
    for (int i = 0; i < 24; i++) begin
      launch(W'($urandom), W'($urandom), 1'($urandom));
      finish_op((i % 5) == 0);
      if ($urandom_range(0, 1) == 0 || i == 23) idle_check();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
